// File: rtl/dfir_cfg_loader_pkg.sv
// Shared definitions for the DFIR configuration loader: FSM encoding and
// buffer slot layout (DCEF, FIR coefficients, isCoefSym, ScalVal).
package dfir_cfg_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } cfgState_t;

  localparam int DCEF_SLOT = 0;
  localparam int COEF_BASE = 1;

  // An order-N filter carries N+1 coefficients starting at COEF_BASE.
  function automatic int symSlot(input int order);
    return COEF_BASE + order + 1;
  endfunction

  function automatic int scalSlot(input int order);
    return symSlot(order) + 1;
  endfunction

  function automatic int wordsForOrder(input int order);
    return scalSlot(order) + 1;
  endfunction

endpackage

// File: rtl/dfir_cfg_loader_cfg_word_ram.sv
// Configuration word buffer: one write port, one registered read port with
// read enable so the read data holds while a word waits for its accept.
module cfg_word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 516,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn && ({1'b0, wrAddr} < DEPTH_W)) begin
      mem[wrAddr] <= wrData;
    end
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/dfir_cfg_loader.sv
// Streams Word_Count buffered configuration words into the DFIR, one word per
// isConfig/isConfigACK handshake, then waits for isConfigDone.
//
// state     | meaning
// S_IDLE    | waiting for Start, host may write the buffer
// S_FETCH   | buffer read of word[index] in flight
// S_SEND    | isConfig high, word held until isConfigACK
// S_WAIT_DONE | all words accepted, waiting for isConfigDone
// S_FINISH  | Done pulse, Busy drops
module dfir_cfg_loader
  import dfir_cfg_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH   = 32,
  parameter int FIR_MAX_ORDER  = 512,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_WORDS      = wordsForOrder(FIR_MAX_ORDER),
  parameter int AW             = $clog2(MAX_WORDS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Host_Wr_En,
  input  logic [AW-1:0]           Host_Wr_Addr,
  input  logic [CONFIG_WIDTH-1:0] Host_Wr_Data,
  input  logic                    Start,
  input  logic [AW:0]             Word_Count,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output logic                    isConfig,
  output logic [CONFIG_WIDTH-1:0] Data_Config_Out,
  input  logic                    isConfigACK,
  input  logic                    isConfigDone
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0] MAX_WC  = (AW+1)'(MAX_WORDS);
  localparam logic [AW:0] IDX_ONE = (AW+1)'(1);
  localparam logic [AW:0] IDX_FIRST = (AW+1)'(DCEF_SLOT);

  cfgState_t         state;
  logic [AW:0]       index;
  logic [AW:0]       wordCnt;
  logic [TW-1:0]     toCnt;
  logic [AW:0]       indexNext;
  logic              lastWord;
  logic              countOk;
  logic              timedOut;
  logic [CONFIG_WIDTH-1:0] rdData;

  assign indexNext = index + IDX_ONE;
  assign lastWord  = (indexNext == wordCnt);
  assign countOk   = (Word_Count != '0) && (Word_Count <= MAX_WC);
  assign timedOut  = (toCnt == TO_LAST);

  cfg_word_ram #(
    .WIDTH (CONFIG_WIDTH),
    .DEPTH (MAX_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk    (CLK),
    .wrEn   (Host_Wr_En && !Busy),
    .wrAddr (Host_Wr_Addr),
    .wrData (Host_Wr_Data),
    .rdEn   (state == S_FETCH),
    .rdAddr (index[AW-1:0]),
    .rdData (rdData)
  );

  // The RAM output register only updates in S_FETCH, so it is already stable
  // for the whole S_SEND stretch; gating with isConfig zeroes it elsewhere.
  assign Data_Config_Out = isConfig ? rdData : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      isConfig <= 1'b0;
      index    <= '0;
      wordCnt  <= '0;
      toCnt    <= '0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (countOk) begin
              wordCnt <= Word_Count;
              index   <= IDX_FIRST;
              Busy    <= 1'b1;
              state   <= S_FETCH;
            end else begin
              Error <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          isConfig <= 1'b1;
          toCnt    <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (isConfigACK) begin
            isConfig <= 1'b0;
            index    <= indexNext;
            if (!lastWord) begin
              state <= S_FETCH;
            end else if (isConfigDone) begin
              Done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              toCnt <= '0;
              state <= S_WAIT_DONE;
            end
          end else if (timedOut) begin
            isConfig <= 1'b0;
            Error    <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            toCnt <= toCnt + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (isConfigDone) begin
            Done  <= 1'b1;
            state <= S_FINISH;
          end else if (timedOut) begin
            Error <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            toCnt <= toCnt + TW'(1);
          end
        end
        S_FINISH: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          isConfig <= 1'b0;
          Busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
